gpr_sb: RTL and testbench
=========================

GPR_SB -- requirements
Module: gpr_sb

Interface
REQ-001 Parameter DW, default 32, data width in bits.
REQ-002 Parameter AW, default 5, address width; depth is 2^AW registers.
REQ-003 Parameter NRD, default 2, number of read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, when 1 register 0 reads as 0 and ignores writes and issues.
REQ-005 Clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Rst  input  1  reset; asynchronous and active-high.
REQ-007 RA  input  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-008 RD  output  NRD*DW  read data; port k occupies bits [k*DW +: DW].
REQ-009 Busy  output  NRD  port k's register has a pending producer not satisfied this cycle.
REQ-010 We  input  1  write enable.
REQ-011 WA  input  AW  write address.
REQ-012 WD  input  DW  write data.
REQ-013 Iss  input  1  issue strobe: mark register IA pending.
REQ-014 IA  input  AW  issue destination address.
REQ-015 Flush  input  1  synchronous clear of all pending bits.
REQ-016 PendCnt  output  AW+1  number of registers currently pending.

Function
REQ-017 Reads SHALL be combinational: RD[k] = WD when We and WA==RA[k] (write-through bypass), else stored value.
REQ-018 With ZERO_REG=1, RA[k]==0 SHALL return 0 regardless of bypass.
REQ-019 On a rising edge with We, reg[WA] SHALL take WD; with ZERO_REG=1 and WA==0 no update.
REQ-020 Each register SHALL have one pending bit; Iss sets pend[IA]; We clears pend[WA].
REQ-021 Iss and We to the same address in one cycle: pend SHALL end set (new producer wins); data still written.
REQ-022 Iss to an already-pending register SHALL leave it set (no counting of producers).
REQ-023 Busy[k] SHALL be pend[RA[k]] AND NOT (We and WA==RA[k]); with ZERO_REG=1, Busy[k]=0 when RA[k]==0.
REQ-024 Flush SHALL clear all pending bits at the edge; a same-cycle Iss SHALL still set pend[IA] (Iss wins over Flush for that address); data writes unaffected.
REQ-025 PendCnt SHALL be a registered population count of pending bits, valid the cycle after each edge, range 0..2^AW (2^AW-1 with ZERO_REG=1).
REQ-026 Out-of-range parameter NRD SHALL be flagged by an elaboration-time error.

Reset
REQ-027 Rst high SHALL immediately clear all registers, all pending bits and PendCnt to 0, independent of Clk.
REQ-028 While Rst is high, We, Iss and Flush SHALL have no effect; RD SHALL show 0 except bypassed WD, Busy SHALL be 0.
REQ-029 Release of Rst mid-sequence SHALL resume from the all-zero state on the next rising edge.

Structure
REQ-030 A shared package SHALL hold the default DW/AW/NRD constants and the NRD range limit.
REQ-031 One sub-module, gpr_sb_popcnt (parameter N, combinational pending-bit counter), SHALL compute PendCnt's next value.
REQ-032 Storage SHALL be a DW-wide array of exactly 2^AW entries; no index outside that range.

Verification
REQ-033 Reset: write 0xDEADBEEF to r5, assert Rst -> RD for r5 reads 0 without a clock edge, PendCnt=0.
REQ-034 Bypass: We=1, WA=7, WD=0x12345678, RA0=7 same cycle -> RD0=0x12345678 before the edge, Busy0=0.
REQ-035 Zero reg: Iss IA=0, We WA=0 WD=0xFFFFFFFF -> RD for r0=0, Busy=0, PendCnt unchanged.
REQ-036 Scoreboard: Iss IA=3; next cycle RA1=3 -> Busy1=1, PendCnt=1; We WA=3 -> Busy1=0 that cycle, PendCnt=0 after edge.
REQ-037 Collision: pend[4] set, Iss IA=4 and We WA=4 WD=0x55 same cycle -> reg4=0x55, pend[4] stays 1, PendCnt=1.
REQ-038 Flush: Iss r1,r2,r3 over three cycles (PendCnt=3), then Flush with Iss IA=9 -> PendCnt=1, only r9 Busy.

Source files
------------

// File: rtl/gpr_sb_pkg.sv
// Shared constants for the scoreboarded register file: default geometry and read-port limits.
// Pure declarations; no logic, no latency.
package gpr_sb_pkg;

    localparam int GPR_SB_DW      = 32;
    localparam int GPR_SB_AW      = 5;
    localparam int GPR_SB_NRD     = 2;
    localparam int GPR_SB_NRD_MIN = 1;
    localparam int GPR_SB_NRD_MAX = 4;

    // Elaboration-time legality check for the read-port count.
    function automatic bit gpr_sb_nrd_ok(input int nrd);
        return (nrd >= GPR_SB_NRD_MIN) && (nrd <= GPR_SB_NRD_MAX);
    endfunction

endpackage

// File: rtl/gpr_sb_if.sv
// Bundle of read ports, write port, issue/flush controls and pending count for gpr_sb.
// Master drives addresses/data/strobes; slave returns read data, busy flags and count.
interface gpr_sb_if
    import gpr_sb_pkg::*;
#(
    parameter int DW  = GPR_SB_DW,
    parameter int AW  = GPR_SB_AW,
    parameter int NRD = GPR_SB_NRD
);

    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic [NRD-1:0]    busy;
    logic              we;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    logic              iss;
    logic [AW-1:0]     ia;
    logic              flush;
    logic [AW:0]       pend_cnt;

    modport master (
        output ra, we, wa, wd, iss, ia, flush,
        input  rd, busy, pend_cnt
    );

    modport slave (
        input  ra, we, wa, wd, iss, ia, flush,
        output rd, busy, pend_cnt
    );

endinterface

// File: rtl/gpr_sb_popcnt.sv
// Combinational population count of an N-bit vector.
// Zero latency; no backpressure.
module gpr_sb_popcnt #(
    parameter  int N  = 32,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  i_bits,
    output logic [CW-1:0] o_cnt
);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < N; i++) begin
            o_cnt = o_cnt + CW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/gpr_sb.sv
// Register file with write-through bypass reads and a one-bit-per-register pending scoreboard.
// Reads/busy are combinational, writes/pending update on the clock edge; no backpressure.
module gpr_sb
    import gpr_sb_pkg::*;
#(
    parameter int DW       = GPR_SB_DW,
    parameter int AW       = GPR_SB_AW,
    parameter int NRD      = GPR_SB_NRD,
    parameter int ZERO_REG = 1
) (
    input logic     i_clk,
    input logic     i_rst,
    gpr_sb_if.slave bus
);

    localparam int DEPTH = 2 ** AW;

    generate
        if (!gpr_sb_nrd_ok(NRD)) begin : g_bad_nrd
            $error("gpr_sb: NRD=%0d outside %0d..%0d", NRD, GPR_SB_NRD_MIN, GPR_SB_NRD_MAX);
        end
    endgenerate

    logic [DW-1:0]          r_mem [DEPTH];
    logic [DEPTH-1:0]       r_pend;
    logic [AW:0]            r_pend_cnt;

    logic [DEPTH-1:0]       w_pend_nxt;
    logic [AW:0]            w_pend_cnt_nxt;
    logic                   w_wr_en;
    logic [AW-1:0]          w_ra [NRD];
    logic [NRD-1:0]         w_byp;
    logic [NRD-1:0]         w_zero;
    logic [NRD-1:0][DW-1:0] w_rd;
    logic [NRD-1:0]         w_busy;

    assign w_wr_en = bus.we && !((ZERO_REG != 0) && (bus.wa == '0));

    // Order matters: flush, then write-back clear, then issue set, so a new producer always wins.
    always_comb begin
        w_pend_nxt = bus.flush ? '0 : r_pend;
        if (bus.we) begin
            w_pend_nxt[bus.wa] = 1'b0;
        end
        if (bus.iss) begin
            w_pend_nxt[bus.ia] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_pend_nxt[0] = 1'b0;
        end
    end

    gpr_sb_popcnt #(
        .N (DEPTH)
    ) u_popcnt (
        .i_bits (w_pend_nxt),
        .o_cnt  (w_pend_cnt_nxt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= w_pend_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[bus.wa] <= bus.wd;
        end
    end

    // Register 0 masking has priority over the bypass so a write to r0 never leaks through.
    always_comb begin
        w_byp  = '0;
        w_zero = '0;
        w_rd   = '0;
        w_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            w_ra[k]   = bus.ra[k*AW +: AW];
            w_byp[k]  = bus.we && (bus.wa == w_ra[k]);
            w_zero[k] = (ZERO_REG != 0) && (w_ra[k] == '0);
            if (w_zero[k]) begin
                w_rd[k] = '0;
            end else if (w_byp[k]) begin
                w_rd[k] = bus.wd;
            end else begin
                w_rd[k] = r_mem[w_ra[k]];
            end
            w_busy[k] = r_pend[w_ra[k]] && !w_byp[k] && !w_zero[k];
        end
    end

    assign bus.rd       = w_rd;
    assign bus.busy     = w_busy;
    assign bus.pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_gpr_sb.sv
module tb_gpr_sb;
    import gpr_sb_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gpr_sb_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

    gpr_sb #(
        .DW       (DW),
        .AW       (AW),
        .NRD      (NRD),
        .ZERO_REG (1)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_pend [DEPTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge.
    task automatic model_edge();
        if (bus.flush) for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
        if (bus.we) begin
            if (bus.wa != 0) m_mem[bus.wa] = bus.wd;
            m_pend[bus.wa] = 1'b0;
        end
        if (bus.iss) m_pend[bus.ia] = 1'b1;
        m_pend[0] = 1'b0;
    endtask

    task automatic check_comb();
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] ra;
            logic [DW-1:0] exp_rd;
            bit            byp;
            bit            exp_busy;
            ra  = bus.ra[k*AW +: AW];
            byp = bus.we && (bus.wa == ra);
            if (ra == 0)  exp_rd = '0;
            else if (byp) exp_rd = bus.wd;
            else          exp_rd = m_mem[ra];
            exp_busy = (ra != 0) && m_pend[ra] && !byp;
            chk($sformatf("rd%0d", k), 64'(bus.rd[k*DW +: DW]), 64'(exp_rd));
            chk($sformatf("busy%0d", k), 64'(bus.busy[k]), 64'(exp_busy));
        end
    endtask

    task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd,
                         input bit iss, input int ia, input bit fl,
                         input int ra0, input int ra1);
        bus.we    = we;
        bus.wa    = AW'(wa);
        bus.wd    = wd;
        bus.iss   = iss;
        bus.ia    = AW'(ia);
        bus.flush = fl;
        bus.ra    = {AW'(ra1), AW'(ra0)};
    endtask

    task automatic idle(input int ra0, input int ra1);
        drive(0, 0, '0, 0, 0, 0, ra0, ra1);
    endtask

    // Called at a falling edge with inputs driven; returns at the next falling edge.
    task automatic step();
        #1;
        check_comb();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        chk("pend_cnt", 64'(bus.pend_cnt), 64'(m_cnt()));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle(0, 0);
        model_clear();
        @(negedge clk);

        chk("rst_pend_cnt", 64'(bus.pend_cnt), 64'd0);
        chk("rst_rd0", 64'(bus.rd[DW-1:0]), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        step();
        rst = 1'b0;

        // Asynchronous reset wipes data and pending state without a clock edge.
        drive(1, 5, 32'hDEADBEEF, 1, 6, 0, 5, 6);
        step();
        idle(5, 6);
        #1;
        chk("r5_stored", 64'(bus.rd[DW-1:0]), 64'hDEADBEEF);
        chk("r6_busy", 64'(bus.busy[1]), 64'd1);
        chk("pend_pre_rst", 64'(bus.pend_cnt), 64'd1);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        chk("rst_async_rd", 64'(bus.rd[DW-1:0]), 64'd0);
        chk("rst_async_cnt", 64'(bus.pend_cnt), 64'd0);
        chk("rst_async_busy", 64'(bus.busy[1]), 64'd0);
        @(negedge clk);

        // Held in reset: bypass visible, but nothing is committed.
        drive(1, 5, 32'hA5A5A5A5, 1, 9, 0, 5, 9);
        #1;
        chk("rst_bypass", 64'(bus.rd[DW-1:0]), 64'hA5A5A5A5);
        step();
        idle(5, 9);
        #1;
        chk("rst_no_write", 64'(bus.rd[DW-1:0]), 64'd0);
        chk("rst_no_iss", 64'(bus.busy[1]), 64'd0);
        rst = 1'b0;
        step();

        // Bypass on a pending register.
        drive(0, 0, '0, 1, 7, 0, 7, 7);
        step();
        drive(1, 7, 32'h12345678, 0, 0, 0, 7, 7);
        #1;
        chk("byp_rd0", 64'(bus.rd[DW-1:0]), 64'h12345678);
        chk("byp_busy0", 64'(bus.busy[0]), 64'd0);
        step();
        chk("byp_cnt", 64'(bus.pend_cnt), 64'd0);

        // Register 0 ignores issue and write.
        drive(0, 0, '0, 1, 2, 0, 0, 2);
        step();
        drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
        #1;
        chk("z_rd0", 64'(bus.rd[DW-1:0]), 64'd0);
        chk("z_busy", 64'(bus.busy), 64'd0);
        step();
        chk("z_cnt", 64'(bus.pend_cnt), 64'd1);
        drive(1, 2, 32'h2, 0, 0, 0, 0, 2);
        step();

        // Issue then write-back.
        drive(0, 0, '0, 1, 3, 0, 0, 0);
        step();
        idle(0, 3);
        #1;
        chk("sb_busy1", 64'(bus.busy[1]), 64'd1);
        chk("sb_cnt1", 64'(bus.pend_cnt), 64'd1);
        step();
        drive(1, 3, 32'h33, 0, 0, 0, 0, 3);
        #1;
        chk("sb_wb_busy1", 64'(bus.busy[1]), 64'd0);
        step();
        chk("sb_cnt0", 64'(bus.pend_cnt), 64'd0);

        // Same-cycle issue and write to a pending register.
        drive(0, 0, '0, 1, 4, 0, 4, 0);
        step();
        drive(1, 4, 32'h55, 1, 4, 0, 4, 0);
        step();
        idle(4, 0);
        #1;
        chk("col_rd", 64'(bus.rd[DW-1:0]), 64'h55);
        chk("col_busy", 64'(bus.busy[0]), 64'd1);
        chk("col_cnt", 64'(bus.pend_cnt), 64'd1);
        drive(1, 4, 32'h44, 0, 0, 0, 4, 0);
        step();

        // Flush with a concurrent issue.
        drive(0, 0, '0, 1, 1, 0, 1, 2);
        step();
        drive(0, 0, '0, 1, 2, 0, 1, 2);
        step();
        drive(0, 0, '0, 1, 3, 0, 1, 2);
        step();
        chk("fl_cnt3", 64'(bus.pend_cnt), 64'd3);
        drive(0, 0, '0, 1, 9, 1, 9, 1);
        step();
        chk("fl_cnt1", 64'(bus.pend_cnt), 64'd1);
        idle(9, 1);
        #1;
        chk("fl_busy9", 64'(bus.busy[0]), 64'd1);
        chk("fl_busy1", 64'(bus.busy[1]), 64'd0);
        step();
        idle(2, 3);
        step();

        // Randomized traffic, small address range half the time to force collisions.
        for (int it = 0; it < 400; it++) begin
            int hi;
            hi = ($urandom_range(0, 1) == 0) ? 7 : DEPTH - 1;
            drive(bit'($urandom_range(0, 1)), $urandom_range(0, hi), DW'($urandom),
                  bit'($urandom_range(0, 9) < 4), $urandom_range(0, hi),
                  bit'($urandom_range(0, 19) == 0),
                  $urandom_range(0, hi), $urandom_range(0, hi));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
